// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single-requester SDRAM controller between a
// read-only video line-fetch port (RD) and a write-only frame-store port (WR).
// It issues one burst command at a time and steers beats to and from the
// owning port. It also keeps a pending WR from being starved by back-to-back
// RD grants.
module sdram_arbiter #(
    parameter int WordLength    = 16,
    parameter int AddressWidth  = 24,
    parameter int BurstLength   = 8,
    parameter int WrStarveLimit = 4,
    parameter int BeatTimeout   = 255
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    i_rd_req,
    input  logic [AddressWidth-1:0] i_rd_addr,
    output logic                    o_rd_ack,
    output logic [WordLength-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_done,
    input  logic                    i_wr_req,
    input  logic [AddressWidth-1:0] i_wr_addr,
    input  logic [WordLength-1:0]   i_wr_data,
    output logic                    o_wr_ack,
    output logic                    o_wr_data_req,
    output logic                    o_wr_done,
    output logic                    o_sdr_enable,
    output logic                    o_sdr_rw,
    output logic [AddressWidth-1:0] o_sdr_addr,
    output logic [WordLength-1:0]   o_sdr_data,
    input  logic [WordLength-1:0]   i_sdr_data,
    input  logic                    i_sdr_valid_wr,
    input  logic                    i_sdr_valid_rd,
    input  logic                    i_sdr_busy,
    output logic                    o_owner,
    output logic                    o_timeout
);

    localparam int BeatW   = $clog2(BurstLength + 1);
    localparam int IdleW   = $clog2(BeatTimeout + 1);
    localparam int StarveW = $clog2(WrStarveLimit + 1);

    localparam logic [BeatW-1:0]        BeatMax   = BeatW'(BurstLength);
    localparam logic [IdleW-1:0]        IdleMax   = IdleW'(BeatTimeout);
    localparam logic [StarveW-1:0]      StarveMax = StarveW'(WrStarveLimit);
    localparam logic [AddressWidth-1:0] AlignMask = ~AddressWidth'(BurstLength - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StBurst,
        StDone
    } stateT;

    stateT                   state_q, state_d;
    logic                    owner_q, owner_d;
    logic [AddressWidth-1:0] addr_q, addr_d;
    logic [StarveW-1:0]      starveCnt_q, starveCnt_d;
    logic [BeatW-1:0]        beatCnt_q, beatCnt_d;
    logic [IdleW-1:0]        idleCnt_q, idleCnt_d;
    logic                    timeout_q, timeout_d;
    logic                    grantWr;
    logic                    strobe;

    assign o_owner   = owner_q;
    assign o_timeout = timeout_q;

    // State, owner, address and counters; reset drops any burst in flight without a done pulse
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            starveCnt_q <= '0;
            beatCnt_q   <= '0;
            idleCnt_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            starveCnt_q <= starveCnt_d;
            beatCnt_q   <= beatCnt_d;
            idleCnt_q   <= idleCnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Arbitration, command issue, beat steering and completion sequencing
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        starveCnt_d   = starveCnt_q;
        beatCnt_d     = beatCnt_q;
        idleCnt_d     = idleCnt_q;
        timeout_d     = timeout_q;
        grantWr       = 1'b0;
        strobe        = owner_q ? i_sdr_valid_wr : i_sdr_valid_rd;
        o_rd_ack      = 1'b0;
        o_rd_valid    = 1'b0;
        o_rd_done     = 1'b0;
        o_rd_data     = i_sdr_data;
        o_wr_ack      = 1'b0;
        o_wr_data_req = 1'b0;
        o_wr_done     = 1'b0;
        o_sdr_enable  = 1'b0;
        o_sdr_rw      = 1'b0;
        o_sdr_addr    = addr_q;
        o_sdr_data    = '0;

        case (state_q)
            StIdle: begin
                if (i_rd_req || i_wr_req) begin
                    grantWr = i_wr_req && (!i_rd_req || (starveCnt_q == StarveMax));
                    owner_d = grantWr;
                    addr_d  = (grantWr ? i_wr_addr : i_rd_addr) & AlignMask;
                    state_d = StIssue;
                    if (grantWr) begin
                        starveCnt_d = '0;
                    end else if (i_wr_req && (starveCnt_q != StarveMax)) begin
                        starveCnt_d = starveCnt_q + 1'b1;
                    end
                end
            end
            StIssue: begin
                o_sdr_enable = 1'b1;
                o_sdr_rw     = !owner_q;
                if (!i_sdr_busy) begin
                    o_rd_ack  = !owner_q;
                    o_wr_ack  = owner_q;
                    state_d   = StBurst;
                    beatCnt_d = '0;
                    idleCnt_d = '0;
                end
            end
            StBurst: begin
                if (strobe) begin
                    idleCnt_d = '0;
                    if (beatCnt_q < BeatMax) begin
                        if (owner_q) begin
                            o_wr_data_req = 1'b1;
                            o_sdr_data    = i_wr_data;
                        end else begin
                            o_rd_valid = 1'b1;
                        end
                        beatCnt_d = beatCnt_q + 1'b1;
                        if (beatCnt_q == BeatMax - 1'b1) begin
                            state_d = StDone;
                        end
                    end
                end else begin
                    idleCnt_d = idleCnt_q + 1'b1;
                    if (idleCnt_q == IdleMax - 1'b1) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StDone: begin
                o_rd_done = !owner_q;
                o_wr_done = owner_q;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (!i_wr_req) begin
            starveCnt_d = '0;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed, table-driven bench for sdram_arbiter. The
// bench itself plays the SDRAM controller (busy and beat strobes) and both
// client ports.
module tb_sdram_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        i_rd_req = 1'b0;
    logic [23:0] i_rd_addr = '0;
    logic        o_rd_ack;
    logic [15:0] o_rd_data;
    logic        o_rd_valid;
    logic        o_rd_done;
    logic        i_wr_req = 1'b0;
    logic [23:0] i_wr_addr = '0;
    logic [15:0] i_wr_data = '0;
    logic        o_wr_ack;
    logic        o_wr_data_req;
    logic        o_wr_done;
    logic        o_sdr_enable;
    logic        o_sdr_rw;
    logic [23:0] o_sdr_addr;
    logic [15:0] o_sdr_data;
    logic [15:0] i_sdr_data = '0;
    logic        i_sdr_valid_wr = 1'b0;
    logic        i_sdr_valid_rd = 1'b0;
    logic        i_sdr_busy = 1'b0;
    logic        o_owner;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rdReq;
        logic        wrReq;
        logic [23:0] rdAddr;
        logic [23:0] wrAddr;
        int          busyCyc;
        logic        expWr;
        logic [23:0] expAddr;
        logic [15:0] base;
    } vecT;

    vecT vecs[5];

    sdram_arbiter dut (
        .CLK(CLK), .RST(RST),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_ack(o_rd_ack),
        .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .o_rd_done(o_rd_done),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_ack(o_wr_ack), .o_wr_data_req(o_wr_data_req), .o_wr_done(o_wr_done),
        .o_sdr_enable(o_sdr_enable), .o_sdr_rw(o_sdr_rw), .o_sdr_addr(o_sdr_addr),
        .o_sdr_data(o_sdr_data), .i_sdr_data(i_sdr_data),
        .i_sdr_valid_wr(i_sdr_valid_wr), .i_sdr_valid_rd(i_sdr_valid_rd),
        .i_sdr_busy(i_sdr_busy), .o_owner(o_owner), .o_timeout(o_timeout)
    );

    // Free-running 10-unit system clock
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Entered at posedge+1 of an IDLE cycle with requests already driven.
    task automatic applyStimulus(input logic expWr, input logic [23:0] expAddr,
                                 input int busyCyc, input bit dropReq);
        #1;
        checkOutput("idle_enable", o_sdr_enable, 0);
        i_sdr_busy = (busyCyc > 0);
        tick();
        for (int c = 0; c < busyCyc; c++) begin
            #1;
            checkOutput("busy_enable", o_sdr_enable, 1);
            checkOutput("busy_addr", o_sdr_addr, expAddr);
            checkOutput("busy_ack", {o_rd_ack, o_wr_ack}, 0);
            tick();
        end
        i_sdr_busy = 1'b0;
        #1;
        checkOutput("issue_enable", o_sdr_enable, 1);
        checkOutput("issue_rw", o_sdr_rw, !expWr);
        checkOutput("issue_addr", o_sdr_addr, expAddr);
        checkOutput("issue_rd_ack", o_rd_ack, !expWr);
        checkOutput("issue_wr_ack", o_wr_ack, expWr);
        checkOutput("issue_owner", o_owner, expWr);
        if (dropReq) begin
            if (expWr) i_wr_req = 1'b0;
            else i_rd_req = 1'b0;
        end
        tick();
    endtask

    // Drives n back-to-back beats; optionally checks the done cycle with a stray extra strobe.
    task automatic runBeats(input logic expWr, input int n, input logic [15:0] base, input bit expDone);
        for (int k = 0; k < n; k++) begin
            if (expWr) begin
                i_sdr_valid_wr = 1'b1;
                i_wr_data = base + 16'(k);
            end else begin
                i_sdr_valid_rd = 1'b1;
                i_sdr_data = base + 16'(k);
            end
            #1;
            if (expWr) begin
                checkOutput("wr_data_req", o_wr_data_req, 1);
                checkOutput("wr_sdr_data", o_sdr_data, base + 16'(k));
                checkOutput("wr_rd_valid", o_rd_valid, 0);
            end else begin
                checkOutput("rd_valid", o_rd_valid, 1);
                checkOutput("rd_data", o_rd_data, base + 16'(k));
                checkOutput("rd_wr_data_req", o_wr_data_req, 0);
                checkOutput("rd_sdr_data", o_sdr_data, 0);
            end
            tick();
        end
        i_sdr_valid_wr = 1'b0;
        i_sdr_valid_rd = 1'b0;
        if (expDone) begin
            if (expWr) i_sdr_valid_wr = 1'b1;
            else i_sdr_valid_rd = 1'b1;
            i_wr_data = base + 16'(n);
            i_sdr_data = base + 16'(n);
            #1;
            checkOutput("done_rd", o_rd_done, !expWr);
            checkOutput("done_wr", o_wr_done, expWr);
            checkOutput("extra_strobe_fwd", {o_rd_valid, o_wr_data_req}, 0);
            checkOutput("extra_strobe_data", o_sdr_data, 0);
            i_sdr_valid_wr = 1'b0;
            i_sdr_valid_rd = 1'b0;
            tick();
        end
    endtask

    initial begin
        int n;
        logic [9:0] grantSeq;

        vecs[0] = '{1'b1, 1'b0, 24'h001234, 24'h000000, 0, 1'b0, 24'h001230, 16'hC000};
        vecs[1] = '{1'b0, 1'b1, 24'h000000, 24'h400008, 0, 1'b1, 24'h400008, 16'hA000};
        vecs[2] = '{1'b1, 1'b0, 24'hFFFFFF, 24'h000000, 3, 1'b0, 24'hFFFFF8, 16'h1234};
        vecs[3] = '{1'b1, 1'b1, 24'h000010, 24'h00002F, 0, 1'b0, 24'h000010, 16'h5A00};
        vecs[4] = '{1'b0, 1'b1, 24'h000010, 24'h00002F, 0, 1'b1, 24'h000028, 16'h0F00};

        // Reset values
        #12;
        checkOutput("rst_enable", o_sdr_enable, 0);
        checkOutput("rst_addr", o_sdr_addr, 0);
        checkOutput("rst_owner", o_owner, 0);
        checkOutput("rst_timeout", o_timeout, 0);
        checkOutput("rst_strobes", {o_rd_ack, o_wr_ack, o_rd_valid, o_wr_data_req, o_rd_done, o_wr_done}, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        tick();

        // Table of single transactions, including a contended grant
        for (int i = 0; i < 5; i++) begin
            i_rd_req  = vecs[i].rdReq;
            i_wr_req  = vecs[i].wrReq;
            i_rd_addr = vecs[i].rdAddr;
            i_wr_addr = vecs[i].wrAddr;
            applyStimulus(vecs[i].expWr, vecs[i].expAddr, vecs[i].busyCyc, 1'b1);
            runBeats(vecs[i].expWr, 8, vecs[i].base, 1'b1);
        end

        // Both requests held: four RD grants, then one WR, repeated
        grantSeq  = 10'b1000010000;
        i_rd_addr = 24'h000200;
        i_wr_addr = 24'h300040;
        i_rd_req  = 1'b1;
        i_wr_req  = 1'b1;
        for (int g = 0; g < 10; g++) begin
            applyStimulus(grantSeq[g], grantSeq[g] ? 24'h300040 : 24'h000200, 0, 1'b0);
            runBeats(grantSeq[g], 8, 16'(16'h2000 + 16'(g) * 16'h0100), 1'b1);
        end
        i_rd_req = 1'b0;
        i_wr_req = 1'b0;

        // Controller busy for 100 cycles while a command waits in ISSUE
        i_rd_req  = 1'b1;
        i_rd_addr = 24'h000100;
        applyStimulus(1'b0, 24'h000100, 100, 1'b1);
        runBeats(1'b0, 8, 16'h7700, 1'b1);

        // Controller stalls after 3 beats: timeout after 255 idle cycles
        i_rd_req  = 1'b1;
        i_rd_addr = 24'h000300;
        applyStimulus(1'b0, 24'h000300, 0, 1'b1);
        runBeats(1'b0, 3, 16'h3300, 1'b0);
        n = 0;
        #1;
        while (o_rd_done !== 1'b1 && n < 400) begin
            @(posedge CLK);
            #2;
            n++;
        end
        checkOutput("timeout_idle_cycles", n, 255);
        checkOutput("timeout_flag", o_timeout, 1);
        checkOutput("timeout_wr_done", o_wr_done, 0);
        tick();
        i_wr_req  = 1'b1;
        i_wr_addr = 24'h123458;
        applyStimulus(1'b1, 24'h123458, 0, 1'b1);
        runBeats(1'b1, 8, 16'hB000, 1'b1);
        checkOutput("timeout_sticky", o_timeout, 1);

        // Reset asserted mid-burst after beat 4
        i_rd_req  = 1'b1;
        i_rd_addr = 24'h000400;
        applyStimulus(1'b0, 24'h000400, 0, 1'b1);
        runBeats(1'b0, 4, 16'h4400, 1'b0);
        i_sdr_valid_rd = 1'b1;
        RST = 1'b0;
        #1;
        checkOutput("midrst_rd_valid", o_rd_valid, 0);
        checkOutput("midrst_enable", o_sdr_enable, 0);
        checkOutput("midrst_addr", o_sdr_addr, 0);
        checkOutput("midrst_owner", o_owner, 0);
        checkOutput("midrst_timeout", o_timeout, 0);
        checkOutput("midrst_done", {o_rd_done, o_wr_done}, 0);
        tick();
        checkOutput("midrst_no_done", {o_rd_done, o_wr_done}, 0);
        i_sdr_valid_rd = 1'b0;
        RST = 1'b1;
        tick();
        i_rd_req  = 1'b1;
        i_rd_addr = 24'h000408;
        applyStimulus(1'b0, 24'h000408, 0, 1'b1);
        runBeats(1'b0, 8, 16'h6600, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
